// File: rtl/serial_alu.sv
// Purpose: handshaked execute unit; logic/arith/compare in one registered cycle, shifts one bit per cycle.
// Latency: 1 cycle for non-shift, illegal and zero-amount shifts; n+1 cycles for a shift by n (max XLEN).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        request handshake; op, a, b captured on accept
//   op[3:0], a, b            ALU control code and operands (shifts use b[$clog2(XLEN)-1:0])
//   out_valid/out_ready      result handshake; out_valid == (state == DONE)
//   result                   registered result
//   zero                     combinational (result == 0)
//   illegal_op               registered flag, high with out_valid for undefined op codes
module serial_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_t;

    state_t         state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    shift_kind_t     shk_q, shk_d;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic            is_shift;
    shift_kind_t     shk_new;
    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign accept     = in_valid & in_ready;
    assign shamt      = b[SHW-1:0];
    assign result     = result_q;
    assign illegal_op = illegal_q;
    assign zero       = (result_q == '0);

    // Single-cycle datapath. For shifts the value loaded is operand a;
    // the actual shifting happens one position per cycle in SHIFT.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        is_shift    = 1'b0;
        shk_new     = SH_SLL;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL: begin
                alu_res  = a;
                is_shift = 1'b1;
                shk_new  = SH_SLL;
            end
            OP_SRL: begin
                alu_res  = a;
                is_shift = 1'b1;
                shk_new  = SH_SRL;
            end
            OP_SRA: begin
                alu_res  = a;
                is_shift = 1'b1;
                shk_new  = SH_SRA;
            end
            default: begin
                alu_res     = '0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        shk_d     = shk_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    result_d  = alu_res;
                    illegal_d = alu_illegal;
                    if (is_shift && (shamt != '0)) begin
                        cnt_d   = shamt;
                        shk_d   = shk_new;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                case (shk_q)
                    SH_SLL:  result_d = {result_q[XLEN-2:0], 1'b0};
                    SH_SRL:  result_d = {1'b0, result_q[XLEN-1:1]};
                    SH_SRA:  result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
                    default: result_d = result_q;
                endcase
                cnt_d = cnt_q - SHW'(1);
                // Last shift step: counter is about to reach zero
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            shk_q     <= SH_SLL;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            shk_q     <= shk_d;
        end
    end

endmodule
